// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, parity/stop checking,
// break detection and a one-word valid/ready output buffer.
module uart_rx_param #(
  parameter int CLK_DIV   = 1250,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, DONE
  } state_e;

  localparam logic [15:0] HALF   = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL   = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_S = 4'(STOP_BITS - 1);

  state_e               state_q;
  logic                 meta_q, rxs_q;
  logic [15:0]          cnt_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] shr_q, data_q;
  logic                 pbit_q, ferr_q, armed_q;
  logic                 valid_q, perr_q, fe_q, brk_q, ovr_q;

  logic tick, accept, xr, perr_d, brk_d;

  assign tick   = (cnt_q == 16'd0);
  assign accept = valid_q && ready;
  assign xr     = (^shr_q) ^ pbit_q;
  assign brk_d  = ferr_q && (shr_q == '0) && (PARITY == 0 || !pbit_q);

  always_comb begin
    perr_d = 1'b0;
    if (PARITY == 1)      perr_d = xr;
    else if (PARITY == 2) perr_d = !xr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
      // A low stop keeps the line from restarting until it is seen high
      if (rxs_q)                          armed_q <= 1'b1;
      else if (state_q == DONE && ferr_q) armed_q <= 1'b0;
      if (accept) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (state_q != IDLE) cnt_q <= tick ? FULL : cnt_q - 16'd1;
      unique case (state_q)
        IDLE: begin
          if (!rxs_q && armed_q) begin
            cnt_q   <= HALF;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              idx_q   <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shr_q <= {rxs_q, shr_q[DATA_BITS-1:1]};
            if (idx_q == LAST_D) begin
              idx_q   <= '0;
              pbit_q  <= 1'b0;
              ferr_q  <= 1'b0;
              state_q <= (PARITY != 0) ? PAR : STOP;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            pbit_q  <= rxs_q;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (!rxs_q) ferr_q <= 1'b1;
            if (idx_q == LAST_S) state_q <= DONE;
            else                 idx_q <= idx_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!valid_q || accept) begin
            data_q  <= shr_q;
            perr_q  <= perr_d;
            fe_q    <= ferr_q;
            brk_q   <= brk_d;
            valid_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = fe_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven with random
// and directed frames, scored against a frame-level reference model.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst;
  logic rx_l[3];
  logic rdy[3];
  logic vld[3], perr[3], ferr[3], brk[3], ovr[3], bsy[3];
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int pass_n = 0;
  int tot_n  = 0;
  int cyc    = 0;
  int st_cyc = 0;
  int vcyc[3];

  int divk[3] = '{16, 16, 13};
  int nbk[3]  = '{8, 8, 7};
  int park[3] = '{0, 1, 2};
  int nsk[3]  = '{1, 1, 2};

  logic [11:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .data(d0), .valid(vld[0]),
    .ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .break_det(brk[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .data(d1), .valid(vld[1]),
    .ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .break_det(brk[1]), .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_param #(.CLK_DIV(13), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .data(d2), .valid(vld[2]),
    .ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .break_det(brk[2]), .overrun(ovr[2]), .busy(bsy[2]));

  // Each accepted word is logged as {break, frame, parity, data}
  always @(negedge clk) begin
    if (vld[0] && rdy[0]) begin
      q0.push_back({brk[0], ferr[0], perr[0], 1'b0, d0});
      vcyc[0] = cyc;
    end
    if (vld[1] && rdy[1]) begin
      q1.push_back({brk[1], ferr[1], perr[1], 1'b0, d1});
      vcyc[1] = cyc;
    end
    if (vld[2] && rdy[2]) begin
      q2.push_back({brk[2], ferr[2], perr[2], 2'b0, d2});
      vcyc[2] = cyc;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [14:0] outs(int k);
    case (k)
      0:       return {bsy[0], ovr[0], brk[0], ferr[0], perr[0], vld[0], 1'b0, d0};
      1:       return {bsy[1], ovr[1], brk[1], ferr[1], perr[1], vld[1], 1'b0, d1};
      default: return {bsy[2], ovr[2], brk[2], ferr[2], perr[2], vld[2], 2'b0, d2};
    endcase
  endfunction

  task automatic take(int k, output int n, output logic [11:0] w);
    w = '0;
    case (k)
      0: begin n = q0.size(); if (n > 0) w = q0[0]; q0.delete(); end
      1: begin n = q1.size(); if (n > 0) w = q1[0]; q1.delete(); end
      default: begin n = q2.size(); if (n > 0) w = q2[0]; q2.delete(); end
    endcase
  endtask

  task automatic wait_clk(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_(int k, logic b);
    rx_l[k] = b;
    wait_clk(divk[k]);
  endtask

  // Expected flags from the frame as sent on the line
  function automatic logic [11:0] model(int k, logic [8:0] d, logic pb,
                                        logic [1:0] st);
    logic fe, pe, be;
    int   ones;
    fe = 1'b0;
    for (int i = 0; i < nsk[k]; i++) if (!st[i]) fe = 1'b1;
    ones = $countones(d) + int'(pb);
    pe = 1'b0;
    if (park[k] == 1) pe = (ones % 2) == 1;
    if (park[k] == 2) pe = (ones % 2) == 0;
    be = fe && (d == 9'd0) && (park[k] == 0 || pb == 1'b0);
    return {be, fe, pe, d};
  endfunction

  task automatic send(int k, logic [8:0] din, bit pflip, logic [1:0] stops,
                      output logic [11:0] exp);
    logic [8:0] d;
    logic       pb;
    d  = din & ((9'h1 << nbk[k]) - 9'h1);
    pb = ($countones(d) % 2) == 1;
    if (park[k] == 2) pb = !pb;
    pb = pb ^ pflip;
    if (park[k] == 0) pb = 1'b0;
    bit_(k, 1'b0);
    for (int i = 0; i < nbk[k]; i++) bit_(k, d[i]);
    if (park[k] != 0) bit_(k, pb);
    st_cyc = cyc;
    for (int i = 0; i < nsk[k]; i++) bit_(k, stops[i]);
    rx_l[k] = 1'b1;
    exp = model(k, d, pb, stops);
  endtask

  task automatic frame_chk(string tag, int k, logic [8:0] d, bit pflip,
                           logic [1:0] stops);
    logic [11:0] exp, w;
    int          n;
    send(k, d, pflip, stops, exp);
    wait_clk(2 * divk[k]);
    take(k, n, w);
    chk({tag, "_cnt"}, n, 1);
    chk({tag, "_word"}, w, exp);
  endtask

  initial begin
    logic [11:0] e1, w;
    int          n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rx_l[k] = 1'b1;
      rdy[k]  = 1'b1;
    end
    wait_clk(3);
    for (int k = 0; k < 3; k++) chk("reset_outs", outs(k), 0);
    rst = 1'b0;
    wait_clk(4);

    frame_chk("a5", 0, 9'h0A5, 1'b0, 2'b11);
    chk("latency", ((vcyc[0] - st_cyc) >= 10 && (vcyc[0] - st_cyc) <= 14), 1);

    frame_chk("par_bad", 1, 9'h003, 1'b1, 2'b11);
    frame_chk("par_ok", 1, 9'h003, 1'b0, 2'b11);
    frame_chk("stop2_low", 2, 9'h055, 1'b0, 2'b01);

    rdy[0] = 1'b0;
    send(0, 9'h011, 1'b0, 2'b11, e1);
    wait_clk(16);
    send(0, 9'h022, 1'b0, 2'b11, w);
    wait_clk(32);
    chk("ovr_valid", vld[0], 1);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_flag", ovr[0], 1);
    rdy[0] = 1'b1;
    wait_clk(1);
    rdy[0] = 1'b0;
    chk("acc_valid", vld[0], 0);
    chk("acc_ovr", ovr[0], 0);
    take(0, n, w);
    chk("acc_cnt", n, 1);
    chk("acc_word", w, e1);
    rdy[0] = 1'b1;

    rx_l[0] = 1'b0;
    wait_clk(5);
    chk("glitch_busy", bsy[0], 1);
    rx_l[0] = 1'b1;
    wait_clk(40);
    chk("glitch_idle", bsy[0], 0);
    take(0, n, w);
    chk("glitch_cnt", n, 0);

    rx_l[0] = 1'b0;
    wait_clk(20 * 16);
    take(0, n, w);
    chk("brk_cnt", n, 1);
    chk("brk_word", w, 12'hC00);
    wait_clk(64);
    take(0, n, w);
    chk("brk_hold_cnt", n, 0);
    rx_l[0] = 1'b1;
    wait_clk(32);
    take(0, n, w);
    chk("brk_rel_cnt", n, 0);
    chk("brk_rel_busy", bsy[0], 0);
    frame_chk("after_brk", 0, 9'h05A, 1'b0, 2'b11);

    rdy[0] = 1'b0;
    send(0, 9'h077, 1'b0, 2'b11, w);
    wait_clk(32);
    bit_(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_(0, 1'(8'h3C >> i));
    rx_l[0] = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("midrst_outs", outs(k), 0);
    wait_clk(3);
    rst = 1'b0;
    rdy[0] = 1'b1;
    wait_clk(5);
    take(0, n, w);
    frame_chk("after_rst", 0, 9'h03C, 1'b0, 2'b11);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12; i++) begin
        logic [8:0] d;
        logic [1:0] st;
        bit         pf;
        d  = 9'($urandom);
        if ($urandom_range(0, 7) == 0) d = '0;
        pf = (park[k] != 0) && ($urandom_range(0, 3) == 0);
        st = 2'b11;
        if ($urandom_range(0, 4) == 0) st = 2'($urandom);
        frame_chk("rand", k, d, pf, st);
        wait_clk($urandom_range(0, 20));
      end
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
